// File: rtl/shift_in_if.sv
// shift_in_if: serial input, frame sync, handshake and status bundle for shift_in.
// Ports: si/sync/out_ready/clr_ovr flow master->slave; dout/out_valid/busy/overrun flow back.
// master = upstream/downstream environment, slave = the deserialiser.
interface shift_in_if #(
   parameter int WIDTH = 8
);
   logic             si;
   logic             sync;
   logic             out_ready;
   logic             clr_ovr;
   logic [WIDTH-1:0] dout;
   logic             out_valid;
   logic             busy;
   logic             overrun;

   modport master (
      output si, sync, out_ready, clr_ovr,
      input  dout, out_valid, busy, overrun
   );

   modport slave (
      input  si, sync, out_ready, clr_ovr,
      output dout, out_valid, busy, overrun
   );
endinterface

// File: rtl/shift_in.sv
// shift_in: deserialises a sync-framed bit stream into WIDTH-bit words, MSB or LSB first.
// Ports: clk, resetq (async active-low), bus (shift_in_if.slave: si, sync, out_ready,
// clr_ovr in; dout, out_valid, busy, overrun out). Word valid the cycle after its last bit.
module shift_in #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic      clk,
   input  logic      resetq,
   shift_in_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic [WIDTH-1:0] sr_start;
   logic             start;
   logic             last;
   logic             load;
   logic             drop;

   // sr_shift is the register after taking si; on the last bit it is the finished word.
   assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], bus.si} : {bus.si, sr[WIDTH-1:1]};
   assign sr_start = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.si} : {bus.si, {(WIDTH-1){1'b0}}};

   // State register
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic: a word always completes on bit WIDTH, even if sync restarts the count.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.sync)        state_nxt = SHIFT;
         SHIFT:   if (cnt == LAST_CNT) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      start    = 1'b0;
      last     = 1'b0;
      bus.busy = 1'b0;
      case (state)
         IDLE: start = bus.sync;
         SHIFT: begin
            bus.busy = 1'b1;
            last     = (cnt == LAST_CNT);
            // sync on the completing edge is ignored
            start    = bus.sync && !last;
         end
         default: ;
      endcase
   end

   // The held word may be replaced on the very edge it is consumed.
   assign load = last && (!bus.out_valid || bus.out_ready);
   assign drop = last && bus.out_valid && !bus.out_ready;

   // Shift register and bit counter
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         sr  <= '0;
         cnt <= '0;
      end else if (start) begin
         sr  <= sr_start;
         cnt <= CW'(1);
      end else if (state == SHIFT) begin
         sr  <= sr_shift;
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

   // Output word, valid flag and sticky overrun
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         bus.dout      <= '0;
         bus.out_valid <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         if (load) begin
            bus.dout      <= sr_shift;
            bus.out_valid <= 1'b1;
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end

         // a new drop wins over a simultaneous clear
         if (drop)             bus.overrun <= 1'b1;
         else if (bus.clr_ovr) bus.overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_shift_in.sv
// tb_shift_in: drives MSB-first and LSB-first shift_in instances with shared serial stimulus.
// Expected words are queued as frames are sent and compared when each word is accepted;
// direct checks cover reset, busy, overrun, restart and async reset behaviour.
module tb_shift_in;
   logic clk;
   logic resetq;
   logic si;
   logic sync;
   logic out_ready;
   logic clr_ovr;

   int checks;
   int failures;

   bit rdy_all;
   bit rdy_last;
   bit clr_last;
   bit sync_last;

   logic [7:0] qa[$];
   logic [7:0] qb[$];

   shift_in_if #(.WIDTH(8)) ifa ();
   shift_in_if #(.WIDTH(8)) ifb ();

   assign ifa.si        = si;
   assign ifa.sync      = sync;
   assign ifa.out_ready = out_ready;
   assign ifa.clr_ovr   = clr_ovr;
   assign ifb.si        = si;
   assign ifb.sync      = sync;
   assign ifb.out_ready = out_ready;
   assign ifb.clr_ovr   = clr_ovr;

   shift_in #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .resetq(resetq), .bus(ifa));
   shift_in #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .resetq(resetq), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: a word is compared on the cycle downstream accepts it.
   always @(negedge clk) begin
      if (resetq && ifa.out_valid && out_ready) begin
         chk("sb_a_pending", qa.size() != 0, 1);
         if (qa.size() != 0) chk("sb_a_word", ifa.dout, qa.pop_front());
      end
      if (resetq && ifb.out_valid && out_ready) begin
         chk("sb_b_pending", qb.size() != 0, 1);
         if (qb.size() != 0) chk("sb_b_word", ifb.dout, qb.pop_front());
      end
   end

   // Sends one 8-bit frame, first bit first on the wire (w[7] first).
   task automatic send_frame(input logic [7:0] w, input bit push);
      for (int i = 0; i < 8; i++) begin
         sync      = (i == 0) || (sync_last && i == 7);
         si        = w[7-i];
         out_ready = rdy_all || (rdy_last && i == 7);
         clr_ovr   = clr_last && i == 7;
         tick();
         if (i < 7) chk("busy_mid", ifa.busy, 1);
      end
      sync      = 1'b0;
      clr_ovr   = 1'b0;
      out_ready = 1'b0;
      chk("busy_end", ifa.busy, 0);
      if (push) begin
         qa.push_back(w);
         qb.push_back(rev8(w));
      end
   endtask

   task automatic partial(input int n);
      for (int i = 0; i < n; i++) begin
         sync = (i == 0);
         si   = 1'b1;
         tick();
      end
      sync = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      rdy_all   = 0;
      rdy_last  = 0;
      clr_last  = 0;
      sync_last = 0;
      si        = 1'b0;
      sync      = 1'b0;
      out_ready = 1'b0;
      clr_ovr   = 1'b0;
      resetq    = 1'b1;
      #1 resetq = 1'b0;
      #1;
      chk("rst_dout_a", ifa.dout, 0);
      chk("rst_dout_b", ifb.dout, 0);
      chk("rst_valid", ifa.out_valid, 0);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_overrun", ifa.overrun, 0);
      #5 resetq = 1'b1;

      // Basic frame immediately after reset release; held (out_ready low)
      send_frame(8'hAE, 1);
      chk("basic_valid", ifa.out_valid, 1);
      chk("basic_dout_msb", ifa.dout, 8'hAE);
      chk("basic_dout_lsb", ifb.dout, 8'h75);

      // Overrun: second word dropped; clear on the same edge loses to the set
      clr_last = 1;
      send_frame(8'h55, 0);
      clr_last = 0;
      chk("ovr_dout_kept", ifa.dout, 8'hAE);
      chk("ovr_valid", ifa.out_valid, 1);
      chk("ovr_set", ifa.overrun, 1);
      chk("ovr_set_b", ifb.overrun, 1);
      tick();
      chk("ovr_sticky", ifa.overrun, 1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("ovr_cleared", ifa.overrun, 0);

      // Replace: held word consumed on the same edge the next completes
      rdy_last = 1;
      send_frame(8'h3C, 1);
      rdy_last = 0;
      chk("repl_dout", ifa.dout, 8'h3C);
      chk("repl_valid", ifa.out_valid, 1);
      chk("repl_overrun", ifa.overrun, 0);
      drain();
      chk("drain_valid", ifa.out_valid, 0);
      chk("drain_dout_kept", ifa.dout, 8'h3C);

      // Restart after 4 bits; sync on the completing edge must be ignored
      partial(4);
      chk("restart_busy", ifa.busy, 1);
      chk("restart_no_out", ifa.out_valid, 0);
      rdy_all   = 1;
      sync_last = 1;
      send_frame(8'hC3, 1);
      rdy_all   = 0;
      sync_last = 0;
      chk("restart_dout", ifa.dout, 8'hC3);
      chk("restart_dout_b", ifb.dout, rev8(8'hC3));
      chk("restart_valid", ifa.out_valid, 1);
      chk("restart_overrun", ifa.overrun, 0);
      tick();
      chk("sync_last_idle", ifa.busy, 0);
      drain();

      // Async reset mid-frame while a word is held
      send_frame(8'h5A, 0);
      partial(5);
      #3 resetq = 1'b0;
      #1;
      chk("arst_dout", ifa.dout, 0);
      chk("arst_valid", ifa.out_valid, 0);
      chk("arst_busy", ifa.busy, 0);
      chk("arst_overrun", ifa.overrun, 0);
      #2 resetq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         si = i[0];
         tick();
         chk("post_rst_idle_valid", ifa.out_valid, 0);
         chk("post_rst_idle_busy", ifa.busy, 0);
      end
      send_frame(8'h96, 1);
      chk("post_rst_dout", ifa.dout, 8'h96);
      chk("post_rst_dout_b", ifb.dout, 8'h69);
      chk("post_rst_valid", ifa.out_valid, 1);
      drain();

      tick();
      chk("sb_a_drained", qa.size(), 0);
      chk("sb_b_drained", qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
